// File: rtl/dw_window_router.sv
// Sliding KSIZE-row window router: buffers row segments and emits strided KSIZE x BUFW windows.
// Optional zero-row top/bottom padding is built when DW_WINDOW_ROUTER_ROWPAD_EN is defined.
module dw_window_router #(
    parameter int DW     = 32,
    parameter int POX    = 16,
    parameter int KSIZE  = 3,
    parameter int STRIDE = 1,
    localparam int BUFW  = (POX - 1) * STRIDE + KSIZE
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic [15:0]                        cfg_rows,
`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
    input  logic                               pad_en,
`endif
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [BUFW-1:0][DW-1:0]            in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [KSIZE-1:0][BUFW-1:0][DW-1:0] out_win,
    output logic                               out_last,
    output logic                               busy,
    output logic                               blkend,
    output logic                               cfg_err
);

    localparam int          PAD = (KSIZE - 1) / 2;
    localparam logic [15:0] K16 = 16'(KSIZE);

    typedef enum logic [1:0] {IDLE, FILL, RUN, DONE} state_t;

    state_t                              state_r;
    state_t                              state_s;
    logic [15:0]                         rows_r;
    logic [15:0]                         acc_r;
    logic [15:0]                         win_r;
    logic [15:0]                         nwin_r;
    logic                                phase_r;
    logic [KSIZE-1:0][BUFW-1:0][DW-1:0]  rowreg_r;
    logic                                out_valid_r;
    logic                                out_last_r;
    logic                                busy_r;
    logic                                blkend_r;
    logic                                cfg_err_r;

    logic        pad_in_s;
    logic        pad_s;
    logic        inject_s;
    logic        inj_done_next_s;
    logic [15:0] min_rows_s;
    logic        start_ok_s;
    logic        start_bad_s;
    logic [15:0] diff_s;
    logic [15:0] nwin_s;
    logic [15:0] fill_tgt_s;
    logic        in_ready_s;
    logic        in_hs_s;
    logic        out_hs_s;
    logic        shift_s;
    logic        produce_s;
    logic [15:0] acc_next_s;
    logic [15:0] win_next_s;
    logic        ov_next_s;

`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
    logic       pad_r;
    logic [1:0] inj_r;

    assign pad_in_s        = pad_en;
    assign pad_s           = pad_r;
    // Bottom padding rows are shifted in once every real row has been taken.
    assign inject_s        = pad_r && (state_r == RUN) && (acc_r == rows_r) &&
                             (inj_r != 2'(PAD)) && (!out_valid_r || out_ready);
    assign inj_done_next_s = !pad_r || ((inj_r + {1'b0, inject_s}) == 2'(PAD));

    // Padding mode and injected-row count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pad_r <= 1'b0;
            inj_r <= 2'd0;
        end else if (start_ok_s) begin
            pad_r <= pad_en;
            inj_r <= 2'd0;
        end else if (inject_s) begin
            pad_r <= pad_r;
            inj_r <= inj_r + 2'd1;
        end else begin
            pad_r <= pad_r;
            inj_r <= inj_r;
        end
    end
`else
    assign pad_in_s        = 1'b0;
    assign pad_s           = 1'b0;
    assign inject_s        = 1'b0;
    assign inj_done_next_s = 1'b1;
`endif

    assign min_rows_s  = pad_in_s ? 16'd1 : K16;
    assign start_ok_s  = (state_r == IDLE) && start && (cfg_rows >= min_rows_s);
    assign start_bad_s = (state_r == IDLE) && start && (cfg_rows < min_rows_s);
    // With padding, total rows = cfg_rows + 2*PAD = cfg_rows + KSIZE - 1.
    assign diff_s      = pad_in_s ? (cfg_rows - 16'd1) : (cfg_rows - K16);
    assign nwin_s      = ((STRIDE == 2) ? (diff_s >> 1) : diff_s) + 16'd1;
    assign fill_tgt_s  = pad_s ? 16'(KSIZE - 1 - PAD) : 16'(KSIZE - 1);

    assign in_ready_s = ((state_r == FILL) || (state_r == RUN)) && (acc_r < rows_r) &&
                        (!out_valid_r || out_ready);
    assign in_hs_s    = in_valid && in_ready_s;
    assign out_hs_s   = out_valid_r && out_ready;
    assign shift_s    = in_hs_s || inject_s;
    // Register is full in RUN; phase picks every STRIDE-th row until the window budget is spent.
    assign produce_s  = shift_s && (state_r == RUN) && !phase_r && (win_r != nwin_r);
    assign acc_next_s = acc_r + {15'd0, in_hs_s};
    assign win_next_s = win_r + {15'd0, produce_s};
    assign ov_next_s  = produce_s || (out_valid_r && !out_ready);

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_ok_s) state_s = FILL;
                else            state_s = IDLE;
            end
            FILL: begin
                if (acc_next_s == fill_tgt_s) state_s = RUN;
                else                          state_s = FILL;
            end
            RUN: begin
                if ((acc_next_s == rows_r) && inj_done_next_s &&
                    (win_next_s == nwin_r) && !ov_next_s) state_s = DONE;
                else                                      state_s = RUN;
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_r <= IDLE;
        else        state_r <= state_s;
    end

    // Block counters and row shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rows_r   <= 16'd0;
            acc_r    <= 16'd0;
            win_r    <= 16'd0;
            nwin_r   <= 16'd0;
            phase_r  <= 1'b0;
            rowreg_r <= '0;
        end else if (start_ok_s) begin
            rows_r   <= cfg_rows;
            acc_r    <= 16'd0;
            win_r    <= 16'd0;
            nwin_r   <= nwin_s;
            phase_r  <= 1'b0;
            rowreg_r <= '0;
        end else if (shift_s) begin
            for (int i = 0; i < KSIZE - 1; i++) begin
                rowreg_r[i] <= rowreg_r[i+1];
            end
            rowreg_r[KSIZE-1] <= in_hs_s ? in_data : '0;
            acc_r <= acc_next_s;
            win_r <= win_next_s;
            if ((STRIDE == 2) && (state_r == RUN)) phase_r <= ~phase_r;
            else                                   phase_r <= phase_r;
        end else begin
            acc_r   <= acc_r;
            win_r   <= win_r;
            phase_r <= phase_r;
        end
    end

    // Registered status and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            busy_r      <= 1'b0;
            blkend_r    <= 1'b0;
            cfg_err_r   <= 1'b0;
        end else begin
            out_valid_r <= ov_next_s;
            if (produce_s)     out_last_r <= (win_r == (nwin_r - 16'd1));
            else if (out_hs_s) out_last_r <= 1'b0;
            else               out_last_r <= out_last_r;
            busy_r    <= (state_s != IDLE);
            blkend_r  <= (state_s == DONE);
            cfg_err_r <= start_bad_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign out_win   = rowreg_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;
    assign blkend    = blkend_r;
    assign cfg_err   = cfg_err_r;

endmodule

// File: tb/tb_dw_window_router.sv
// Bench for dw_window_router: stride-1 and stride-2 instances, vector table plus scoreboard queue.
module tb_dw_window_router;

    localparam int DW  = 8;
    localparam int POX = 2;
    localparam int K   = 3;
    localparam int BW1 = (POX - 1) * 1 + K;
    localparam int BW2 = (POX - 1) * 2 + K;

    typedef logic [K-1:0][BW2-1:0][DW-1:0] win_t;
    typedef struct { win_t win; bit last; } exp_t;
    typedef struct {
        int sel; int rows; int stall_at; int stall_len; bit mid_start; int exp_win;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [15:0] cfg_rows = 16'd0;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic [BW2-1:0][DW-1:0] in_data = '0;
    int sel = 0;
`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
    logic pad_en = 1'b0;
`endif

    logic a_in_ready, a_out_valid, a_out_last, a_busy, a_blkend, a_cfg_err;
    logic b_in_ready, b_out_valid, b_out_last, b_busy, b_blkend, b_cfg_err;
    logic [K-1:0][BW1-1:0][DW-1:0] a_out_win;
    logic [K-1:0][BW2-1:0][DW-1:0] b_out_win;
    logic m_in_ready, m_out_valid, m_out_last, m_busy, m_blkend, m_cfg_err;
    win_t m_out_win;

    logic start_a, start_b, in_valid_a, in_valid_b;
    assign start_a    = start && (sel == 0);
    assign start_b    = start && (sel == 1);
    assign in_valid_a = in_valid && (sel == 0);
    assign in_valid_b = in_valid && (sel == 1);

    dw_window_router #(.DW(DW), .POX(POX), .KSIZE(K), .STRIDE(1)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cfg_rows(cfg_rows),
`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
        .pad_en(pad_en),
`endif
        .in_valid(in_valid_a), .in_ready(a_in_ready), .in_data(in_data[BW1-1:0]),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_win(a_out_win),
        .out_last(a_out_last), .busy(a_busy), .blkend(a_blkend), .cfg_err(a_cfg_err)
    );

    dw_window_router #(.DW(DW), .POX(POX), .KSIZE(K), .STRIDE(2)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cfg_rows(cfg_rows),
`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
        .pad_en(1'b0),
`endif
        .in_valid(in_valid_b), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_win(b_out_win),
        .out_last(b_out_last), .busy(b_busy), .blkend(b_blkend), .cfg_err(b_cfg_err)
    );

    always #5 clk = ~clk;

    always_comb begin
        m_out_win = '0;
        if (sel == 0) begin
            for (int i = 0; i < K; i++)
                for (int j = 0; j < BW1; j++)
                    m_out_win[i][j] = a_out_win[i][j];
            m_in_ready = a_in_ready; m_out_valid = a_out_valid; m_out_last = a_out_last;
            m_busy = a_busy; m_blkend = a_blkend; m_cfg_err = a_cfg_err;
        end else begin
            m_out_win = b_out_win;
            m_in_ready = b_in_ready; m_out_valid = b_out_valid; m_out_last = b_out_last;
            m_busy = b_busy; m_blkend = b_blkend; m_cfg_err = b_cfg_err;
        end
    end

    int pass_cnt = 0;
    int total_cnt = 0;
    exp_t sq[$];
    int mreg[K];
    int midx, mwin, nwin_m, stride_m, bufw_m;
    bit pad_m, mid_start_c;
    int rows_c, sent, pops, blk, cyc, stall_at_c, stall_left;
    vec_t vecs[8];

    task automatic check(input string name, input logic [119:0] act, input logic [119:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pix(input int r, input int j);
        return DW'(r * 8 + j + 1);
    endfunction

    function automatic logic [BW2-1:0][DW-1:0] mkrow(input int r);
        logic [BW2-1:0][DW-1:0] v;
        for (int j = 0; j < BW2; j++) v[j] = pix(r, j);
        return v;
    endfunction

    function automatic win_t build();
        win_t w = '0;
        for (int i = 0; i < K; i++)
            for (int j = 0; j < bufw_m; j++)
                if (mreg[i] >= 0) w[i][j] = pix(mreg[i], j);
        return w;
    endfunction

    // Reference: row index e produces a window iff e >= K-1 and (e-(K-1)) mod S == 0, within the window budget.
    task automatic model_shift(input int id);
        exp_t e;
        for (int i = 0; i < K - 1; i++) mreg[i] = mreg[i+1];
        mreg[K-1] = id;
        if (midx >= K - 1 && ((midx - (K - 1)) % stride_m) == 0 && mwin < nwin_m) begin
            e.win = build();
            e.last = (mwin == nwin_m - 1);
            sq.push_back(e);
            mwin++;
        end
        midx++;
    endtask

    task automatic model_accept(input int r);
        model_shift(r);
        if (pad_m && r == rows_c - 1)
            for (int p = 0; p < (K - 1) / 2; p++) model_shift(-1);
    endtask

    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (m_out_valid && out_ready) begin
            if (sq.size() == 0) begin
                total_cnt++;
                $display("FAIL extra_window: got window %h with empty scoreboard", m_out_win);
            end else begin
                e = sq.pop_front();
                check("win", m_out_win, e.win);
                check("last", m_out_last, e.last);
            end
            pops++;
        end else if (m_out_valid) begin
            check("stall_in_ready", m_in_ready, 1'b0);
            if (sq.size() > 0) check("stall_win", m_out_win, sq[0].win);
        end
        if (in_valid && m_in_ready) begin
            model_accept(sent);
            sent++;
        end
        if (m_blkend) begin
            blk++;
            check("blkend_after_rows", sent, rows_c);
        end
        @(posedge clk);
        #1;
        cyc++;
        start = mid_start_c && (cyc == 3);
        if (start) cfg_rows = 16'd3;
        in_valid = (sent < rows_c);
        in_data = mkrow(sent);
        if (m_out_valid && pops == stall_at_c && stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = 1'b1;
        end
    endtask

    task automatic run_case(input vec_t v, input bit pad, input int abort_at);
        sel = v.sel;
        stride_m = (v.sel != 0) ? 2 : 1;
        bufw_m = (v.sel != 0) ? BW2 : BW1;
        rows_c = v.rows;
        pad_m = pad;
        stall_at_c = v.stall_at;
        stall_left = v.stall_len;
        mid_start_c = v.mid_start;
        nwin_m = pad ? (v.rows - 1) / stride_m + 1 : (v.rows - K) / stride_m + 1;
        for (int i = 0; i < K; i++) mreg[i] = -1;
        midx = pad ? (K - 1) / 2 : 0;
        mwin = 0; sq.delete(); sent = 0; pops = 0; blk = 0; cyc = 0;
`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
        pad_en = pad;
`endif
        start = 1'b1; cfg_rows = 16'(v.rows); out_ready = 1'b1; in_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", m_busy, 1'b1);
        in_valid = 1'b1;
        in_data = mkrow(0);
        while (blk == 0 && cyc < 300 && !(abort_at > 0 && pops >= abort_at)) cycle();
        if (abort_at > 0) return;
        repeat (3) cycle();
        check("blkend_once", blk, 1);
        check("window_count", pops, v.exp_win);
        check("queue_empty", sq.size(), 0);
        check("busy_idle", m_busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{0, 5, -1, 0, 1'b0, 3};
        vecs[1] = '{1, 6, -1, 0, 1'b0, 2};
        vecs[2] = '{0, 5,  1, 4, 1'b0, 3};
        vecs[3] = '{0, 5, -1, 0, 1'b1, 3};
        vecs[4] = '{0, 3, -1, 0, 1'b0, 1};
        vecs[5] = '{1, 7,  0, 2, 1'b0, 3};
        vecs[6] = '{0, 8,  2, 1, 1'b0, 6};
        vecs[7] = '{1, 5, -1, 0, 1'b0, 2};

        #2;
        check("reset_a", {a_in_ready, a_out_valid, a_out_last, a_busy, a_blkend, a_cfg_err}, 6'd0);
        check("reset_b", {b_in_ready, b_out_valid, b_out_last, b_busy, b_blkend, b_cfg_err}, 6'd0);
        check("reset_win", a_out_win, '0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        sel = 0; start = 1'b1; cfg_rows = 16'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("cfg_err_pulse", m_cfg_err, 1'b1);
        check("cfg_err_busy", m_busy, 1'b0);
        @(posedge clk);
        #1;
        check("cfg_err_clear", m_cfg_err, 1'b0);
        check("cfg_err_idle", m_busy, 1'b0);

        for (int n = 0; n < 8; n++) run_case(vecs[n], 1'b0, 0);

        run_case(vecs[0], 1'b0, 2);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_outs", {m_in_ready, m_out_valid, m_out_last, m_busy, m_blkend, m_cfg_err}, 6'd0);
        check("midrst_win", m_out_win, '0);
        repeat (2) begin
            @(negedge clk);
            check("midrst_no_blkend", m_blkend, 1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_case(vecs[0], 1'b0, 0);

`ifdef DW_WINDOW_ROUTER_ROWPAD_EN
        run_case('{0, 4, -1, 0, 1'b0, 4}, 1'b1, 0);
        run_case('{0, 1, -1, 0, 1'b0, 1}, 1'b1, 0);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/dw_window_router.md
DW_WINDOW_ROUTER -- requirements
Module: dw_window_router

Interface
REQ-001 SHALL have parameter DW, default 32: pixel width in bits.
REQ-002 SHALL have parameter POX, default 16: output pixels per row.
REQ-003 SHALL have parameter KSIZE, default 3: kernel height/width. Legal values are 3 and 5.
REQ-004 SHALL have parameter STRIDE, default 1: row and column stride. Legal values are 1 and 2.
REQ-005 SHALL have derived localparam BUFW = (POX-1)*STRIDE+KSIZE: pixels per row segment.
REQ-006 SHALL have ports, clock and reset first:
- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous, active-low.
- start  in  1  begin a block.
- cfg_rows  in  16  input rows in the block; sampled on accepted start.
- in_valid  in  1  input row segment valid.
- in_ready  out  1  input row segment accepted when high with in_valid.
- in_data  in  BUFW x DW  one row segment.
- out_valid  out  1  window valid.
- out_ready  in  1  consumer ready.
- out_win  out  KSIZE x BUFW x DW  window rows; index 0 = oldest row.
- out_last  out  1  final window of the block.
- busy  out  1  high when state is not IDLE.
- blkend  out  1  one-cycle pulse at block completion.
- cfg_err  out  1  one-cycle pulse when start is rejected.

Function
REQ-007 SHALL implement the FSM states IDLE, FILL, RUN, DONE.
REQ-008 IDLE: start with a legal cfg_rows SHALL latch cfg_rows and enter FILL; cfg_rows < KSIZE SHALL pulse cfg_err and remain in IDLE.
REQ-009 SHALL ignore start when not in IDLE.
REQ-010 SHALL keep a KSIZE-deep row shift register; each accepted row SHALL shift in at index KSIZE-1.
REQ-011 FILL SHALL accept KSIZE-1 rows without output, then enter RUN.
REQ-012 SHALL number accepted rows r from 0; row r SHALL produce a window iff r >= KSIZE-1 and (r-(KSIZE-1)) mod STRIDE == 0.
REQ-013 out_valid SHALL rise the cycle after the producing row handshake; out_win SHALL be the register contents after that shift.
REQ-014 Window count SHALL be floor((cfg_rows-KSIZE)/STRIDE)+1.
REQ-015 Rows after the last producing row SHALL be accepted and discarded.
REQ-016 in_ready SHALL equal: (FILL or RUN) and rows accepted < cfg_rows and (!out_valid or out_ready).
- in_ready is combinational on out_ready.
REQ-017 While out_valid=1 and out_ready=0, out_win and out_last SHALL hold stable; no window SHALL be dropped or duplicated.
REQ-018 out_last SHALL be high only with the final window.
REQ-019 SHALL enter DONE once the final window has handshaken and all cfg_rows are accepted; DONE SHALL pulse blkend for one cycle, then return to IDLE.
REQ-020 Row and window counters SHALL be 16 bits; at cfg_rows=65535 no wrap SHALL occur before DONE.

Reset
REQ-021 On rst_n low, state SHALL be IDLE and counters and row registers zero.
REQ-022 During reset, in_ready, out_valid, out_last, busy, blkend and cfg_err SHALL be 0.
REQ-023 Reset mid-block SHALL abandon the block; no blkend SHALL be produced.

Configuration
REQ-024 With macro DW_WINDOW_ROUTER_ROWPAD_EN defined, the block SHALL add input port pad_en (1 bit), sampled on accepted start.
REQ-025 When pad_en=1, P=(KSIZE-1)/2 zero rows SHALL be preloaded on top, and FILL SHALL accept only KSIZE-1-P rows.
REQ-026 When pad_en=1, P zero rows SHALL be injected internally after the last input row, without an input handshake.
REQ-027 When pad_en=1, window count SHALL be floor((cfg_rows-1)/STRIDE)+1, and the minimum legal cfg_rows SHALL be 1.
REQ-028 Without the macro, the pad_en port and the padding logic SHALL be absent, and behaviour SHALL be REQ-001..023.

Verification
REQ-029 K=3,S=1, cfg_rows=5, rows R0..R4, out_ready=1 -> 3 windows {R0,R1,R2},{R1,R2,R3},{R2,R3,R4}; out_last on the 3rd; blkend once.
REQ-030 K=3,S=2, cfg_rows=6 -> 2 windows {R0-R2},{R2-R4}; R5 accepted and discarded; blkend after R5 is accepted.
REQ-031 K=3,S=1, cfg_rows=5, out_ready low 4 cycles at the 2nd window -> out_win stable, in_ready=0 while stalled, identical 3 windows.
REQ-032 cfg_rows=2, K=3 -> cfg_err pulse, busy stays 0; a start during RUN is ignored.
REQ-033 rst_n low after the 2nd window -> all outputs 0 immediately; a new start with cfg_rows=5 completes normally.
REQ-034 Macro defined, pad_en=1, K=3,S=1, cfg_rows=4 -> 4 windows; first = {0,R0,R1}, last = {R2,R3,0}.
